// File: rtl/timer_bank_if.sv
// Address and strobe bundle of the shared memory-mapped bus as seen by the timer bank.
// The bidirectional data lines are a separate port of the timer bank itself.
interface timer_bank_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] busAddr;
    logic              busEn;
    logic              busWr;

    modport master (output busAddr, output busEn, output busWr);
    modport slave  (input  busAddr, input  busEn, input  busWr);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counting timer bank with per-channel prescaler, one-shot or
// auto-reload mode, and a write-1-to-clear pending flag ORed onto one interrupt line.
// Each channel owns four registers: CTRL, RELOAD, COUNT, STATUS (address bits [1:0]).
module timer_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic             clk,
    input  logic             rstn,
    timer_bank_if.slave      bus,
    inout  wire  [WIDTH-1:0] busData,
    output logic             sigIntr
);
    typedef enum logic {IDLE, RUN} chan_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [ADDR_W-1:0] sel_chan;
    logic [1:0]        sel_reg;
    logic              wr_access;
    logic              rd_access;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  rd_data;

    chan_state_t       state_q   [CHANNELS];
    chan_state_t       state_d   [CHANNELS];
    logic [7:0]        presc_q   [CHANNELS];
    logic [7:0]        pre_cnt_q [CHANNELS];
    logic [WIDTH-1:0]  reload_q  [CHANNELS];
    logic [WIDTH-1:0]  count_q   [CHANNELS];
    logic [CHANNELS-1:0] auto_q;
    logic [CHANNELS-1:0] ie_q;
    logic [CHANNELS-1:0] pend_q;

    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_reload;
    logic [CHANNELS-1:0] wr_count;
    logic [CHANNELS-1:0] wr_status;
    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] expire;

    assign sel_chan  = bus.busAddr >> 2;
    assign sel_reg   = bus.busAddr[1:0];
    assign wr_access = bus.busEn & bus.busWr;
    assign rd_access = bus.busEn & ~bus.busWr;
    assign wr_data   = busData;

    // Decode a bus write into per-channel register strobes; out-of-range channels match nothing.
    always_comb begin
        wr_ctrl   = '0;
        wr_reload = '0;
        wr_count  = '0;
        wr_status = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_access && sel_chan == ADDR_W'(i)) begin
                wr_ctrl[i]   = (sel_reg == REG_CTRL);
                wr_reload[i] = (sel_reg == REG_RELOAD);
                wr_count[i]  = (sel_reg == REG_COUNT);
                wr_status[i] = (sel_reg == REG_STATUS);
            end
        end
    end

    // Channel state register: RUN is the EN bit of CTRL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
        end
    end

    // Next state: a CTRL write sets EN directly, a one-shot expiry drops back to IDLE.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            if (wr_ctrl[i]) begin
                state_d[i] = wr_data[0] ? RUN : IDLE;
            end else if (expire[i] && !auto_q[i]) begin
                state_d[i] = IDLE;
            end
        end
    end

    // Per-channel tick and expiry; a CTRL or COUNT write in the same cycle swallows the tick.
    always_comb begin
        running = '0;
        tick    = '0;
        expire  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            running[i] = (state_q[i] == RUN);
            tick[i]    = running[i] && (pre_cnt_q[i] == presc_q[i]) && !wr_ctrl[i] && !wr_count[i];
            expire[i]  = tick[i] && (count_q[i] == '0);
        end
    end

    // Register file, prescalers and counters; a RELOAD write coincident with a reload wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                presc_q[i]   <= '0;
                pre_cnt_q[i] <= '0;
                reload_q[i]  <= '0;
                count_q[i]   <= '0;
            end
            auto_q <= '0;
            ie_q   <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ctrl[i]) begin
                    auto_q[i]  <= wr_data[1];
                    ie_q[i]    <= wr_data[2];
                    presc_q[i] <= wr_data[15:8];
                end

                if (wr_reload[i]) begin
                    reload_q[i] <= wr_data;
                end

                if (wr_ctrl[i] || wr_count[i] || !running[i] || (pre_cnt_q[i] == presc_q[i])) begin
                    pre_cnt_q[i] <= '0;
                end else begin
                    pre_cnt_q[i] <= pre_cnt_q[i] + 8'd1;
                end

                if (wr_count[i]) begin
                    count_q[i] <= wr_data;
                end else if (tick[i]) begin
                    if (count_q[i] != '0) begin
                        count_q[i] <= count_q[i] - WIDTH'(1);
                    end else if (auto_q[i]) begin
                        count_q[i] <= wr_reload[i] ? wr_data : reload_q[i];
                    end
                end

                if (expire[i]) begin
                    pend_q[i] <= 1'b1;
                end else if (wr_status[i] && wr_data[0]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read mux for the addressed register; unmapped bits and missing channels read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_chan == ADDR_W'(i)) begin
                case (sel_reg)
                    REG_CTRL: begin
                        rd_data[0]    = running[i];
                        rd_data[1]    = auto_q[i];
                        rd_data[2]    = ie_q[i];
                        rd_data[15:8] = presc_q[i];
                    end
                    REG_RELOAD: rd_data = reload_q[i];
                    REG_COUNT:  rd_data = count_q[i];
                    default:    rd_data[0] = pend_q[i];
                endcase
            end
        end
    end

    assign busData = rd_access ? rd_data : 'z;
    assign sigIntr = |(pend_q & ie_q);
endmodule
